// File: rtl/exu_muldiv_if.sv
// rtl/exu_muldiv_if.sv - operand/result handshake bundle between EXU and the mul/div unit
interface exu_muldiv_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  // EXU side: issues operands, consumes the result
  modport master (
    output in_valid, op, src1, src2, out_ready,
    input  in_ready, out_valid, result, busy
  );

  // Unit side
  modport slave (
    input  in_valid, op, src1, src2, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/exu_muldiv.sv
// rtl/exu_muldiv.sv - iterative RV32M multiply/divide unit, one bit per cycle
module exu_muldiv #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  exu_muldiv_if.slave   io
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [XLEN-1:0]      INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]      ALL_ONES = {XLEN{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(XLEN);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t                 state_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [2:0]             op_q;
  logic                   neg_res_q;   // product / quotient must be negated in FIX
  logic                   neg_rem_q;   // remainder takes the dividend sign
  logic [XLEN-1:0]        a_q;         // |multiplicand|
  logic [XLEN-1:0]        b_q;         // |divisor|
  logic [2*XLEN-1:0]      prod_q;      // {accumulator, remaining multiplier bits}
  logic [XLEN-1:0]        rem_q;       // partial remainder (always < divisor)
  logic [XLEN-1:0]        quo_q;       // dividend bits shifting out, quotient bits shifting in
  logic [XLEN-1:0]        result_q;
  logic                   out_valid_q;
  logic                   in_ready_q;
  logic                   busy_q;

  // accept-side decode
  logic                   s1_signed;
  logic                   s2_signed;
  logic                   src1_neg;
  logic                   src2_neg;
  logic [XLEN-1:0]        mag1;
  logic [XLEN-1:0]        mag2;
  logic                   fast_hit;
  logic [XLEN-1:0]        fast_res;

  // iteration and fix-up next values
  logic [XLEN:0]          mul_sum;
  logic [2*XLEN-1:0]      prod_d;
  logic [XLEN:0]          div_shift;
  logic [XLEN+1:0]        div_diff;
  logic                   div_ge;
  logic [XLEN-1:0]        rem_d;
  logic [XLEN-1:0]        quo_d;
  logic [2*XLEN-1:0]      prod_fix;
  logic [XLEN-1:0]        quo_fix;
  logic [XLEN-1:0]        rem_fix;
  logic [XLEN-1:0]        result_d;

  // Operand sign handling and divide-by-zero / overflow shortcuts on accept
  always_comb begin
    s1_signed = (io.op == 3'd0) || (io.op == 3'd1) || (io.op == 3'd2) ||
                (io.op == 3'd4) || (io.op == 3'd6);
    s2_signed = (io.op == 3'd0) || (io.op == 3'd1) ||
                (io.op == 3'd4) || (io.op == 3'd6);
    src1_neg  = s1_signed && io.src1[XLEN-1];
    src2_neg  = s2_signed && io.src2[XLEN-1];
    mag1      = src1_neg ? (~io.src1 + 1'b1) : io.src1;
    mag2      = src2_neg ? (~io.src2 + 1'b1) : io.src2;
    fast_hit  = 1'b0;
    fast_res  = '0;
    if (io.op[2]) begin
      if (io.src2 == '0) begin
        fast_hit = 1'b1;
        fast_res = io.op[1] ? io.src1 : ALL_ONES;
      end else if (!io.op[0] && (io.src1 == INT_MIN) && (io.src2 == ALL_ONES)) begin
        fast_hit = 1'b1;
        fast_res = io.op[1] ? '0 : io.src1;
      end
    end
  end

  // One shift-add multiply step and one restoring-divide step per cycle
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    prod_d    = {mul_sum, prod_q[XLEN-1:1]};
    div_shift = {rem_q, quo_q[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    div_ge    = !div_diff[XLEN+1];
    rem_d     = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    quo_d     = {quo_q[XLEN-2:0], div_ge};
  end

  // Sign restoration and result selection used in FIX
  always_comb begin
    prod_fix = neg_res_q ? (~prod_q + 1'b1) : prod_q;
    quo_fix  = neg_res_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix  = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    if (op_q[2]) begin
      result_d = op_q[1] ? rem_fix : quo_fix;
    end else if (op_q == 3'd0) begin
      result_d = prod_fix[XLEN-1:0];
    end else begin
      result_d = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // Control FSM and datapath registers, outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (io.in_valid) begin
            op_q       <= io.op;
            neg_res_q  <= src1_neg ^ src2_neg;
            neg_rem_q  <= src1_neg;
            a_q        <= mag1;
            b_q        <= mag2;
            prod_q     <= {{XLEN{1'b0}}, mag2};
            rem_q      <= '0;
            quo_q      <= mag1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (fast_hit) begin
              result_q    <= fast_res;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              cnt_q   <= CNT_LOAD;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (op_q[2]) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
          end else begin
            prod_q <= prod_d;
          end
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          result_q    <= result_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.busy      = busy_q;

endmodule

// File: tb/tb_exu_muldiv.sv
// tb/tb_exu_muldiv.sv - self-checking bench for exu_muldiv (XLEN=32 and XLEN=8 instances)
module tb_exu_muldiv;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  exu_muldiv_if #(.XLEN(32)) mif ();
  exu_muldiv_if #(.XLEN(8))  mif8 ();

  exu_muldiv #(.XLEN(32), .CNT_WIDTH(6)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (mif)
  );

  exu_muldiv #(.XLEN(8), .CNT_WIDTH(4)) dut8 (
    .clk_i (clk),
    .rst_i (rst),
    .io    (mif8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural RV32M reference using 64-bit host arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 3'd4 && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return 32'h0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    int n;
    n   = 0;
    res = '0;
    lat = 0;
    while (!mif.in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!mif.in_ready) begin
      check("accept_timeout", 64'(mif.in_ready), 64'd1);
      return;
    end
    mif.in_valid = 1'b1;
    mif.op       = op;
    mif.src1     = a;
    mif.src2     = b;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    lat = 1;
    n   = 0;
    while (!mif.out_valid && n < 200) begin
      @(posedge clk); #1; lat++; n++;
    end
    if (!mif.out_valid) begin
      check("result_timeout", 64'(mif.out_valid), 64'd1);
      return;
    end
    res = mif.result;
  endtask

  task automatic do_op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output int lat);
    int n;
    n   = 0;
    res = '0;
    lat = 0;
    while (!mif8.in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!mif8.in_ready) begin
      check("accept8_timeout", 64'(mif8.in_ready), 64'd1);
      return;
    end
    mif8.in_valid = 1'b1;
    mif8.op       = op;
    mif8.src1     = a;
    mif8.src2     = b;
    @(posedge clk); #1;
    mif8.in_valid = 1'b0;
    lat = 1;
    n   = 0;
    while (!mif8.out_valid && n < 200) begin
      @(posedge clk); #1; lat++; n++;
    end
    if (!mif8.out_valid) begin
      check("result8_timeout", 64'(mif8.out_valid), 64'd1);
      return;
    end
    res = mif8.result;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic [7:0]  res8;
    logic [31:0] held;
    int          lat;
    int          pulses;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    mif.in_valid  = 1'b0;
    mif.op        = '0;
    mif.src1      = '0;
    mif.src2      = '0;
    mif.out_ready = 1'b1;
    mif8.in_valid = 1'b0;
    mif8.op       = '0;
    mif8.src1     = '0;
    mif8.src2     = '0;
    mif8.out_ready = 1'b1;

    vecs.push_back('{"mul_7x6",         3'd0, 32'd7,        32'd6,        32'h0000_002A, 34});
    vecs.push_back('{"mulh_m1xm1",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34});
    vecs.push_back('{"mulhu_m1xm1",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
    vecs.push_back('{"mulhsu_m1x2",     3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 34});
    vecs.push_back('{"div_m7_2",        3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34});
    vecs.push_back('{"rem_m7_2",        3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34});
    vecs.push_back('{"divu_100_7",      3'd5, 32'd100,      32'd7,        32'd14,        34});
    vecs.push_back('{"remu_100_7",      3'd7, 32'd100,      32'd7,        32'd2,         34});
    vecs.push_back('{"divu_5_0",        3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF, 1});
    vecs.push_back('{"rem_13_0",        3'd6, 32'd13,       32'd0,        32'd13,        1});
    vecs.push_back('{"div_ovf",         3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{"rem_ovf",         3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
    vecs.push_back('{"mul_min_m1",      3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34});
    vecs.push_back('{"div_min_1",       3'd4, 32'h8000_0000, 32'd1,        32'h8000_0000, 34});
    vecs.push_back('{"rem_7_m2",        3'd6, 32'd7,        32'hFFFF_FFFE, 32'd1,         34});
    vecs.push_back('{"mulh_min_min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34});

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready",  64'(mif.in_ready),  64'd1);
    check("reset_busy",      64'(mif.busy),      64'd0);
    check("reset_out_valid", 64'(mif.out_valid), 64'd0);
    check("reset_result",    64'(mif.result),    64'd0);

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec_%s_result", vecs[i].name), 64'(res), 64'(vecs[i].exp));
      check($sformatf("vec_%s_latency", vecs[i].name), 64'(lat), 64'(vecs[i].lat));
    end

    for (int k = 0; k < 60; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      do_op(rop, ra, rb, res, lat);
      check($sformatf("rand%0d_op%0d_%h_%h_result", k, rop, ra, rb), 64'(res),
            64'(ref_model(rop, ra, rb)));
      check($sformatf("rand%0d_op%0d_latency", k, rop), 64'(lat), 64'(ref_lat(rop, ra, rb)));
    end

    // Back-pressure in DONE: result held, new operands ignored, then released
    @(posedge clk); #1;
    mif.out_ready = 1'b0;
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, res, lat);
    check("stall_first_result", 64'(res), 64'hFFFF_FFFD);
    held          = mif.result;
    mif.in_valid  = 1'b1;
    mif.op        = 3'd0;
    mif.src1      = 32'd3;
    mif.src2      = 32'd5;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d_out_valid", c), 64'(mif.out_valid), 64'd1);
      check($sformatf("stall%0d_result", c),    64'(mif.result),    64'(held));
      check($sformatf("stall%0d_in_ready", c),  64'(mif.in_ready),  64'd0);
    end
    mif.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", 64'(mif.out_valid), 64'd0);
    check("release_in_ready",  64'(mif.in_ready),  64'd1);
    check("release_result_hold", 64'(mif.result),  64'hFFFF_FFFD);
    @(posedge clk); #1;
    check("next_accept_busy",  64'(mif.busy),      64'd1);
    mif.in_valid = 1'b0;
    lat = 1;
    while (!mif.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check("next_op_latency", 64'(lat), 64'd34);
    check("next_op_result",  64'(mif.result), 64'd15);

    // Reset in the middle of CALC aborts the operation
    @(posedge clk); #1;
    do_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, res, lat);
    check("pre_abort_result", 64'(res), 64'(ref_model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0)));
    @(posedge clk); #1;
    mif.in_valid = 1'b1;
    mif.op       = 3'd0;
    mif.src1     = 32'd123;
    mif.src2     = 32'd456;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    check("abort_busy_before", 64'(mif.busy), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready",  64'(mif.in_ready),  64'd1);
    check("abort_busy",      64'(mif.busy),      64'd0);
    check("abort_out_valid", 64'(mif.out_valid), 64'd0);
    check("abort_result",    64'(mif.result),    64'd0);
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (mif.out_valid) pulses++;
    end
    check("abort_no_pulse", 64'(pulses), 64'd0);

    // Narrow instance
    do_op8(3'd3, 8'hFF, 8'hFF, res8, lat);
    check("x8_mulhu_result",  64'(res8), 64'hFE);
    check("x8_mulhu_latency", 64'(lat),  64'd10);
    do_op8(3'd4, 8'hF9, 8'h02, res8, lat);
    check("x8_div_result",    64'(res8), 64'hFD);
    check("x8_div_latency",   64'(lat),  64'd10);
    do_op8(3'd5, 8'h05, 8'h00, res8, lat);
    check("x8_divu0_result",  64'(res8), 64'hFF);
    check("x8_divu0_latency", 64'(lat),  64'd1);
    do_op8(3'd0, 8'd13, 8'd11, res8, lat);
    check("x8_mul_result",    64'(res8), 64'h8F);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
